// File: rtl/fetch_unit.sv
// Instruction fetch stage with IF/ID register and a single-outstanding req/ack imem port.
// Optional perf counters (perf_bubble_cnt, perf_kill_cnt) are enabled by defining FETCH_PERF_CNT_EN.
module fetch_unit #(
  parameter int unsigned      XLEN     = 32,
  parameter logic [XLEN-1:0]  RESET_PC = '0,
  parameter logic [31:0]      NOP_INST = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            stall,
  input  logic            flush,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  output logic [XLEN-1:0] ID_pc,
  output logic [31:0]     ID_inst,
  output logic            ID_valid,
  output logic [1:0]      dbg_state_o
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]     perf_bubble_cnt,
  output logic [31:0]     perf_kill_cnt
`endif
);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, HELD = 2'd2, KILL = 2'd3} state_t;

  localparam logic [XLEN-1:0] PC_STEP    = XLEN'(4);
  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

  state_t          state_q;
  logic [XLEN-1:0] pc_q, pend_pc_q, buf_pc_q, id_pc_q;
  logic [31:0]     buf_inst_q, id_inst_q;
  logic            id_valid_q, id_valid_d, req_q;
  logic [XLEN-1:0] redir_pc;

  assign redir_pc = redirect_pc & ALIGN_MASK;

  // Next value of ID_valid, shared by the FSM and the bubble counter.
  always_comb begin
    id_valid_d = id_valid_q;
    case (state_q)
      IDLE: id_valid_d = id_valid_q;
      REQ:  id_valid_d = flush ? 1'b0 : (stall ? id_valid_q : imem_ack);
      HELD: id_valid_d = flush ? 1'b0 : (stall ? id_valid_q : 1'b1);
      KILL: id_valid_d = (flush || !stall) ? 1'b0 : id_valid_q;
      default: id_valid_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      pend_pc_q  <= '0;
      buf_pc_q   <= '0;
      buf_inst_q <= '0;
      id_pc_q    <= '0;
      id_inst_q  <= NOP_INST;
      id_valid_q <= 1'b0;
      req_q      <= 1'b0;
    end else begin
      id_valid_q <= id_valid_d;
      case (state_q)
        IDLE: begin
          state_q <= REQ;
          req_q   <= 1'b1;
        end
        REQ: begin
          if (imem_ack) begin
            if (flush) begin
              pc_q      <= redir_pc;
              id_inst_q <= NOP_INST;
            end else if (!stall) begin
              id_pc_q   <= pc_q;
              id_inst_q <= imem_rdata;
              pc_q      <= pc_q + PC_STEP;
            end else begin
              buf_pc_q   <= pc_q;
              buf_inst_q <= imem_rdata;
              pc_q       <= pc_q + PC_STEP;
              state_q    <= HELD;
              req_q      <= 1'b0;
            end
          end else if (flush) begin
            // Request cannot be withdrawn: keep it asserted and drop its response later.
            pend_pc_q <= redir_pc;
            id_inst_q <= NOP_INST;
            state_q   <= KILL;
          end else if (!stall) begin
            id_inst_q <= NOP_INST;
          end
        end
        HELD: begin
          if (flush) begin
            pc_q      <= redir_pc;
            id_inst_q <= NOP_INST;
            state_q   <= REQ;
            req_q     <= 1'b1;
          end else if (!stall) begin
            id_pc_q   <= buf_pc_q;
            id_inst_q <= buf_inst_q;
            state_q   <= REQ;
            req_q     <= 1'b1;
          end
        end
        KILL: begin
          if (flush) pend_pc_q <= redir_pc;
          if (flush || !stall) id_inst_q <= NOP_INST;
          if (imem_ack) begin
            pc_q    <= flush ? redir_pc : pend_pc_q;
            state_q <= REQ;
          end
        end
        default: begin
          state_q <= IDLE;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  // In KILL pc_q still holds the killed request address, so it drives the port unchanged.
  assign imem_req    = req_q;
  assign imem_addr   = pc_q & ALIGN_MASK;
  assign ID_pc       = id_pc_q;
  assign ID_inst     = id_inst_q;
  assign ID_valid    = id_valid_q;
  assign dbg_state_o = state_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] bubble_cnt_q, kill_cnt_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      bubble_cnt_q <= '0;
      kill_cnt_q   <= '0;
    end else begin
      if (!id_valid_d) bubble_cnt_q <= bubble_cnt_q + 32'd1;
      if (imem_ack && ((state_q == KILL) || (state_q == REQ && flush)))
        kill_cnt_q <= kill_cnt_q + 32'd1;
    end
  end

  assign perf_bubble_cnt = bubble_cnt_q;
  assign perf_kill_cnt   = kill_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table, reset-in-KILL sequence, and a
// randomized run against a program-order reference model with a variable-latency memory.
module tb_fetch_unit;

  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [31:0] RST_PC   = 32'h0000_0000;
  localparam logic [31:0] JUNK     = 32'hDEAD_BEEF;
  localparam int          N_RAND   = 3000;

  logic        clk, reset_n, stall, flush, imem_ack;
  logic [31:0] redirect_pc, imem_rdata;
  logic        imem_req, ID_valid;
  logic [31:0] imem_addr, ID_pc, ID_inst;
  logic [1:0]  dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  fetch_unit #(.XLEN(32), .RESET_PC(RST_PC), .NOP_INST(NOP)) dut (
    .clk(clk), .reset_n(reset_n), .stall(stall), .flush(flush),
    .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .ID_pc(ID_pc),
    .ID_inst(ID_inst), .ID_valid(ID_valid), .dbg_state_o(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // instruction memory contents: a fixed hash of the address
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a * 32'h9E37_79B1 + 32'h0123_4567;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // driver: hold reset for two edges, release 1 time unit after the last reset edge
  task automatic do_reset();
    reset_n = 1'b0; stall = 1'b0; flush = 1'b0; redirect_pc = '0;
    imem_ack = 1'b0; imem_rdata = '0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  // vector table: inputs for one cycle and the outputs visible during that cycle
  typedef struct {
    logic        st, fl;
    logic [31:0] rd;
    logic        ack;
    logic [31:0] rdat;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_inst;
  } vec_t;
  vec_t vq[$];

  task automatic add_vec(input logic st, input logic fl, input logic [31:0] rd,
                         input logic ack, input logic [31:0] rdat, input logic e_req,
                         input logic [31:0] e_addr, input logic e_valid,
                         input logic [31:0] e_pc, input logic [31:0] e_inst);
    vec_t v;
    v.st = st; v.fl = fl; v.rd = rd; v.ack = ack; v.rdat = rdat;
    v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid;
    v.e_pc = e_pc; v.e_inst = e_inst;
    vq.push_back(v);
  endtask

  // scoreboard state for the random phase
  logic [31:0] exp_q[$];
  logic        pst, pfl, pv;
  logic [31:0] prd, ppc, pinst, hold_addr;
  logic        busy;
  int          lat, n_deliv;

  initial begin
    //          st fl redirect      ack rdata              req addr          v  pc            inst
    add_vec(0, 0, 32'h0,        0, 32'h0,              0, 32'h0,         0, 32'h0,         NOP);
    add_vec(0, 0, 32'h0,        1, mem_word(32'h0),    1, 32'h0,         0, 32'h0,         NOP);
    add_vec(0, 0, 32'h0,        1, mem_word(32'h4),    1, 32'h4,         1, 32'h0,         mem_word(32'h0));
    add_vec(1, 0, 32'h0,        1, mem_word(32'h8),    1, 32'h8,         1, 32'h4,         mem_word(32'h4));
    add_vec(1, 0, 32'h0,        0, 32'h0,              0, 32'h0,         1, 32'h4,         mem_word(32'h4));
    add_vec(1, 0, 32'h0,        0, 32'h0,              0, 32'h0,         1, 32'h4,         mem_word(32'h4));
    add_vec(0, 0, 32'h0,        0, 32'h0,              0, 32'h0,         1, 32'h4,         mem_word(32'h4));
    add_vec(0, 0, 32'h0,        1, mem_word(32'hC),    1, 32'hC,         1, 32'h8,         mem_word(32'h8));
    add_vec(0, 1, 32'h100,      1, JUNK,               1, 32'h10,        1, 32'hC,         mem_word(32'hC));
    add_vec(0, 0, 32'h0,        1, mem_word(32'h100),  1, 32'h100,       0, 32'h0,         NOP);
    add_vec(1, 0, 32'h0,        1, mem_word(32'h104),  1, 32'h104,       1, 32'h100,       mem_word(32'h100));
    add_vec(1, 1, 32'h43,       0, 32'h0,              0, 32'h0,         1, 32'h100,       mem_word(32'h100));
    add_vec(0, 0, 32'h0,        1, mem_word(32'h40),   1, 32'h40,        0, 32'h0,         NOP);
    add_vec(0, 0, 32'h0,        0, 32'h0,              1, 32'h44,        1, 32'h40,        mem_word(32'h40));
    add_vec(0, 1, 32'h200,      0, 32'h0,              1, 32'h44,        0, 32'h0,         NOP);
    add_vec(0, 1, 32'h300,      0, 32'h0,              1, 32'h44,        0, 32'h0,         NOP);
    add_vec(0, 0, 32'h0,        1, JUNK,               1, 32'h44,        0, 32'h0,         NOP);
    add_vec(0, 0, 32'h0,        1, mem_word(32'h300),  1, 32'h300,       0, 32'h0,         NOP);
    add_vec(0, 1, 32'hFFFF_FFFC,1, JUNK,               1, 32'h304,       1, 32'h300,       mem_word(32'h300));
    add_vec(0, 0, 32'h0,        1, mem_word(32'hFFFF_FFFC), 1, 32'hFFFF_FFFC, 0, 32'h0,    NOP);
    add_vec(0, 0, 32'h0,        0, 32'h0,              1, 32'h0,         1, 32'hFFFF_FFFC, mem_word(32'hFFFF_FFFC));

    // table phase
    do_reset();
    for (int i = 0; i < vq.size(); i++) begin
      stall = vq[i].st; flush = vq[i].fl; redirect_pc = vq[i].rd;
      imem_ack = vq[i].ack; imem_rdata = vq[i].rdat;
      @(negedge clk);
      chk($sformatf("v%0d_req", i), imem_req, vq[i].e_req);
      if (vq[i].e_req) chk($sformatf("v%0d_addr", i), imem_addr, vq[i].e_addr);
      chk($sformatf("v%0d_valid", i), ID_valid, vq[i].e_valid);
      if (vq[i].e_valid) chk($sformatf("v%0d_pc", i), ID_pc, vq[i].e_pc);
      chk($sformatf("v%0d_inst", i), ID_inst, vq[i].e_inst);
      @(posedge clk); #1;
    end

    // reset while in KILL, then a late ack while IDLE
    stall = 1'b0; flush = 1'b1; redirect_pc = 32'h80; imem_ack = 1'b0;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("kill_req", imem_req, 1'b1);
    chk("kill_addr", imem_addr, 32'h0);
    reset_n = 1'b0;
    @(posedge clk); #1;
    chk("rst_req", imem_req, 1'b0);
    chk("rst_valid", ID_valid, 1'b0);
    chk("rst_inst", ID_inst, NOP);
    reset_n = 1'b1; imem_ack = 1'b1; imem_rdata = JUNK;
    @(posedge clk); #1;
    chk("late_ack_req", imem_req, 1'b1);
    chk("late_ack_addr", imem_addr, RST_PC);
    chk("late_ack_valid", ID_valid, 1'b0);
    imem_ack = 1'b1; imem_rdata = mem_word(RST_PC);
    @(posedge clk); #1;
    imem_ack = 1'b0;
    chk("after_rst_valid", ID_valid, 1'b1);
    chk("after_rst_pc", ID_pc, RST_PC);
    chk("after_rst_inst", ID_inst, mem_word(RST_PC));

    // random phase: each delivered PC must follow program order from the latest redirect
    do_reset();
    exp_q.delete();
    exp_q.push_back(RST_PC);
    busy = 1'b0; lat = 0; n_deliv = 0;
    pst = 1'b0; pfl = 1'b0; prd = '0; pv = 1'b0; ppc = '0; pinst = NOP;
    for (int cyc = 0; cyc < N_RAND; cyc++) begin
      if (cyc > 0) begin
        if (pfl) begin
          chk("rnd_flush_valid", ID_valid, 1'b0);
          chk("rnd_flush_inst", ID_inst, NOP);
          exp_q.delete();
          exp_q.push_back(prd & ~32'h3);
        end else if (pst) begin
          chk("rnd_stall_valid", ID_valid, pv);
          chk("rnd_stall_pc", ID_pc, ppc);
          chk("rnd_stall_inst", ID_inst, pinst);
        end else if (ID_valid) begin
          logic [31:0] e;
          e = exp_q.pop_front();
          chk("rnd_pc", ID_pc, e);
          chk("rnd_inst", ID_inst, mem_word(e));
          exp_q.push_back(e + 32'd4);
          n_deliv++;
        end else begin
          chk("rnd_bubble_inst", ID_inst, NOP);
        end
      end
      // variable-latency memory, 0..3 extra cycles
      if (imem_req) begin
        chk("rnd_addr_align", {30'd0, imem_addr[1:0]}, 32'h0);
        if (!busy) begin
          busy = 1'b1;
          lat = $urandom_range(0, 3);
          hold_addr = imem_addr;
        end else begin
          chk("rnd_addr_stable", imem_addr, hold_addr);
        end
        if (lat == 0) begin
          imem_ack = 1'b1;
          imem_rdata = mem_word(imem_addr);
          busy = 1'b0;
        end else begin
          imem_ack = 1'b0;
          imem_rdata = $urandom;
          lat--;
        end
      end else begin
        if (busy) chk("rnd_req_held", imem_req, 1'b1);
        imem_ack = 1'b0;
      end
      pv = ID_valid; ppc = ID_pc; pinst = ID_inst;
      stall = (cyc < 2) ? 1'b0 : ($urandom_range(0, 3) == 0);
      flush = (cyc < 2) ? 1'b0 : ($urandom_range(0, 9) == 0);
      redirect_pc = $urandom;
      pst = stall; pfl = flush; prd = redirect_pc;
      @(posedge clk); #1;
    end
    chk("rnd_progress", (n_deliv > 100) ? 32'd1 : 32'd0, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
